// File: rtl/aes_block_padder.sv
// Packs a 32-bit byte stream into 128-bit AES blocks and appends PKCS#7 padding.
// A message of len bytes yields ceil((len+1)/16) blocks; len mod 16 = 0 adds a full pad block.
module aes_block_padder #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [31:0]          data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [127:0]         block_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_WIDTH-4:0] blk_cnt_o
);

  localparam int unsigned CntW = LEN_WIDTH - 3;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StEmit,
    StPad
  } state_e;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [1:0]           word_idx_q;
  logic [7:0]           pad_q;
  logic [127:0]         block_q;
  logic [CntW-1:0]      blk_cnt_q;
  logic                 done_q;

  logic [2:0]  take;
  logic        last_word;
  logic [7:0]  start_pad;
  logic [31:0] word_merged;
  logic        word_fire;
  logic        blk_fire;

  // Bytes this word contributes to the message; never more than what remains.
  assign take      = (rem_q >= LEN_WIDTH'(4)) ? 3'd4 : rem_q[2:0];
  assign last_word = (rem_q <= LEN_WIDTH'(4));
  assign start_pad = 8'd16 - {4'd0, len_i[3:0]};

  assign ready_o   = enable_i && (state_q == StFill);
  assign valid_o   = enable_i && ((state_q == StEmit) || (state_q == StPad));
  assign word_fire = valid_i && ready_o;
  assign blk_fire  = valid_o && ready_i;

  // Bytes past the message end are replaced by the pad byte.
  always_comb begin
    word_merged = '0;
    for (int j = 0; j < 4; j++) begin
      word_merged[8*j +: 8] = (3'(j) < take) ? data_i[8*j +: 8] : pad_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      word_idx_q <= '0;
      pad_q      <= '0;
      block_q    <= '0;
      blk_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (enable_i) begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              blk_cnt_q  <= '0;
              rem_q      <= len_i;
              pad_q      <= start_pad;
              word_idx_q <= '0;
              if (len_i == '0) begin
                state_q <= StPad;
                block_q <= {16{8'h10}};
              end else begin
                state_q <= StFill;
                // Pre-fill with pad so words never received are already padded.
                block_q <= {16{start_pad}};
              end
            end
          end
          StFill: begin
            if (word_fire) begin
              rem_q <= rem_q - LEN_WIDTH'(take);
              for (int k = 0; k < 4; k++) begin
                if (word_idx_q == 2'(k)) begin
                  block_q[32*k +: 32] <= word_merged;
                end
              end
              if ((word_idx_q == 2'd3) || last_word) begin
                state_q    <= StEmit;
                word_idx_q <= 2'd0;
              end else begin
                word_idx_q <= word_idx_q + 2'd1;
              end
            end
          end
          StEmit: begin
            if (blk_fire) begin
              blk_cnt_q <= blk_cnt_q + CntW'(1);
              if (rem_q != '0) begin
                state_q <= StFill;
                block_q <= {16{pad_q}};
              end else if (pad_q == 8'd16) begin
                state_q <= StPad;
                block_q <= {16{8'h10}};
              end else begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end
          end
          StPad: begin
            if (blk_fire) begin
              blk_cnt_q <= blk_cnt_q + CntW'(1);
              state_q   <= StIdle;
              done_q    <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign block_o   = block_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign blk_cnt_o = blk_cnt_q;

endmodule

// File: doc/aes_block_padder.md
AES_BLOCK_PADDER -- requirements
Module: aes_block_padder

Interface
REQ-001 SHALL have parameter: LEN_WIDTH, 16, width of the message byte-length input and the internal byte counter.
REQ-002 SHALL have port: clk_i  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: clear_i  input  1  synchronous soft clear, same effect as reset.
REQ-005 SHALL have port: enable_i  input  1  global enable; when low, all state is frozen.
REQ-006 SHALL have port: start_i  input  1  begin a message; sampled only in IDLE.
REQ-007 SHALL have port: len_i  input  LEN_WIDTH  message length in bytes, captured on accepted start_i.
REQ-008 SHALL have port: valid_i / ready_o / data_i  input/output/input  1/1/32  upstream 32-bit word stream.
REQ-009 SHALL have port: valid_o / ready_i / block_o  output/input/output  1/1/128  downstream 128-bit block stream to the AES engine.
REQ-010 SHALL have port: busy_o  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port: done_o  output  1  one-cycle pulse when the final block handshakes.
REQ-012 SHALL have port: blk_cnt_o  output  LEN_WIDTH-3  number of blocks emitted since the last start.

Function
REQ-013 SHALL implement the FSM states IDLE, FILL, EMIT and PADBLK.
REQ-014 Transitions SHALL be:
- IDLE->FILL on start_i with len_i>0.
- IDLE->PADBLK on start_i with len_i=0.
- FILL->EMIT after the 4th word of a block, or after the last message word, is accepted.
- EMIT->FILL on handshake if bytes remain.
- EMIT->PADBLK on handshake if no bytes remain and len mod 16 = 0.
- EMIT->IDLE on handshake otherwise.
- PADBLK->IDLE on handshake.
REQ-015 ready_o SHALL equal enable_i AND (state==FILL); no input word is accepted in any other state.
REQ-016 valid_o SHALL equal enable_i AND (state is EMIT or PADBLK).
REQ-017 block_o SHALL be registered and held stable from valid_o rising until the handshake.
REQ-018 Word k (k=0..3) of a block SHALL occupy block_o[32k+31:32k].
REQ-019 Stream byte 4k+j SHALL be data_i[8j+7:8j].
REQ-020 SHALL accept exactly ceil(len/4) words per message.
REQ-021 Bytes at stream index >= len SHALL be ignored, including the unused bytes of the final word.
REQ-022 Padding SHALL be PKCS#7, with pad byte P = 16 - (len mod 16), range 1..16.
REQ-023 Every byte at or after index len in the final data block SHALL be P.
REQ-024 PADBLK SHALL output 128'h10101010_10101010_10101010_10101010 without consuming input.
REQ-025 valid_o SHALL rise the cycle after the completing word handshake (1-cycle latency).
REQ-026 Best-case throughput SHALL be one block per 5 cycles.
REQ-027 The remaining-byte counter SHALL load len_i on start and decrement by min(4, remaining) per accepted word; it SHALL never wrap below 0.
REQ-028 blk_cnt_o SHALL clear on accepted start_i and increment on each valid_o&ready_i handshake, including PADBLK.
REQ-029 done_o SHALL pulse in the cycle following the final handshake, coincident with the return to IDLE.
REQ-030 start_i SHALL be ignored outside IDLE; len_i SHALL be ignored except when start_i is accepted.
REQ-031 A start_i in the same cycle as done_o (already IDLE) SHALL be accepted.
REQ-032 With enable_i low, state, counters and block_o SHALL hold, and ready_o/valid_o SHALL be 0.
REQ-033 clear_i SHALL take priority over enable_i and start_i.

Reset
REQ-034 On rst_i or clear_i, the following SHALL be 0 at the next edge, with the state in IDLE: state, counters, block_o, valid_o, ready_o, busy_o, done_o, blk_cnt_o.
REQ-035 rst_i asserted mid-message SHALL abandon the message; no partial block SHALL be emitted afterwards.

Verification
REQ-036 Bench SHALL cover these directed scenarios:
- len=16, words 0x03020100,0x07060504,0x0B0A0908,0x0F0E0D0C -> block 0x0F0E0D0C_0B0A0908_07060504_03020100, then all-0x10 block, done_o pulse, blk_cnt_o=2.
- len=5, words 0x44332211,0xDEADBEAA -> exactly 2 words accepted; block 0x0B0B0B0B_0B0B0B0B_0B0B0BAA_44332211; done_o, blk_cnt_o=1.
- len=0 -> ready_o never high; one all-0x10 block; done_o.
- len=32 with ready_i held low 10 cycles during first EMIT -> block_o stable, ready_o=0 throughout; 3 blocks total.
- rst_i after 2 words of len=16 -> all outputs 0 next cycle; new start len=4 then produces 0x0C0C0C0C_0C0C0C0C_0C0C0C0C_<word0>.
- start_i pulsed during FILL with different len_i -> ignored; enable_i low 5 cycles mid-FILL -> no state change, output unchanged after resume.
